// File: rtl/frame_pkg.sv
// Shared definitions for the UART frame path: default geometry, header bytes,
// pixel width and the capture state machine encoding.
package frame_pkg;

  localparam int DEF_W     = 200;
  localparam int DEF_H     = 150;
  localparam int PIX_TOTAL = DEF_W * DEF_H;
  localparam int PIX_W     = 12;
  localparam int IDX_W     = 15;

  localparam logic [7:0] DEF_SYNC0 = 8'hAA;
  localparam logic [7:0] DEF_SYNC1 = 8'h55;

  typedef enum logic [1:0] {
    HUNT0,
    HUNT1,
    DATA,
    DONE
  } frame_state_t;

endpackage

// File: rtl/byte_timeout.sv
// Idle-gap counter: counts clocks while not cleared and saturates at TERMINAL,
// raising terminal for as long as it sits there.
module byte_timeout #(
  parameter logic [23:0] TERMINAL = 24'd4_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic terminal
);

  logic [23:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 24'd0;
    end else if (clear) begin
      count <= 24'd0;
    end else if (count != TERMINAL) begin
      count <= count + 24'd1;
    end
  end

  assign terminal = (count == TERMINAL);

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs the UART byte stream into RGB444 pixels (3 bytes -> 2 pixels) after an
// SYNC0/SYNC1 header, captures one W*H frame per capture window, aborts on idle.
module uart_pixel_packer
  import frame_pkg::*;
#(
  parameter int          W              = DEF_W,
  parameter int          H              = DEF_H,
  parameter logic [7:0]  SYNC0          = DEF_SYNC0,
  parameter logic [7:0]  SYNC1          = DEF_SYNC1,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture_en,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 pix_valid,
  output logic [PIX_W-1:0]     pix_data,
  output logic [IDX_W-1:0]     pix_index,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W * H - 1);

  frame_state_t     state;
  logic [1:0]       phase;
  logic [7:0]       b0_q;
  logic [3:0]       nib_q;
  logic [IDX_W-1:0] pix_cnt;

  logic             idle_clear;
  logic             idle_term;
  logic             timeout_hit;
  logic             emit_now;
  logic [PIX_W-1:0] emit_pix;

  // A byte in the terminal-count cycle wins, so the abort needs an idle cycle.
  assign timeout_hit = (state == DATA) && capture_en && !byte_valid && idle_term;
  assign idle_clear  = !capture_en || (state != DATA) || byte_valid || timeout_hit;

  byte_timeout #(
    .TERMINAL(TIMEOUT_CYCLES - 24'd1)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (idle_clear),
    .terminal(idle_term)
  );

  // Phase 1 completes P0 from the stored b0; phase 2 completes P1 from the stored nibble.
  always_comb begin
    emit_now = (state == DATA) && capture_en && byte_valid && (phase != 2'd0);
    emit_pix = {nib_q, byte_data};
    if (phase == 2'd1) begin
      emit_pix = {b0_q, byte_data[7:4]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT0;
      phase        <= 2'd0;
      b0_q         <= 8'd0;
      nib_q        <= 4'd0;
      pix_cnt      <= '0;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      pix_index    <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (!capture_en) begin
        state        <= HUNT0;
        phase        <= 2'd0;
        pix_cnt      <= '0;
        frame_active <= 1'b0;
      end else begin
        case (state)
          HUNT0: begin
            if (byte_valid && (byte_data == SYNC0)) begin
              state <= HUNT1;
            end
          end

          HUNT1: begin
            if (byte_valid) begin
              if (byte_data == SYNC1) begin
                state        <= DATA;
                phase        <= 2'd0;
                pix_cnt      <= '0;
                frame_active <= 1'b1;
              end else if (byte_data != SYNC0) begin
                state <= HUNT0;
              end
            end
          end

          DATA: begin
            if (timeout_hit) begin
              frame_err    <= 1'b1;
              frame_active <= 1'b0;
              phase        <= 2'd0;
              pix_cnt      <= '0;
              state        <= HUNT0;
            end else if (byte_valid) begin
              phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
              if (phase == 2'd0) begin
                b0_q <= byte_data;
              end
              if (phase == 2'd1) begin
                nib_q <= byte_data[3:0];
              end
              if (emit_now) begin
                pix_valid <= 1'b1;
                pix_data  <= emit_pix;
                pix_index <= pix_cnt;
                pix_cnt   <= pix_cnt + 1'b1;
                if (pix_cnt == LAST_IDX) begin
                  frame_done   <= 1'b1;
                  frame_active <= 1'b0;
                  state        <= DONE;
                end
              end
            end
          end

          DONE: begin
            state <= DONE;
          end

          default: state <= HUNT0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Randomized bench for uart_pixel_packer (W=4, H=2, timeout 16) against a
// byte-list reference model that derives pixels from the packing rule directly.
module tb_uart_pixel_packer;

  localparam int          W      = 4;
  localparam int          H      = 2;
  localparam int          TOTAL  = W * H;
  localparam int          TC_INT = 16;
  localparam logic [23:0] TC     = 24'd16;

  typedef struct packed {
    logic [11:0] data;
    logic [14:0] index;
    logic        done;
    logic        active;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic [14:0] pix_index;
  logic        frame_active;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  int stray_done = 0;

  pix_t act_q[$];
  pix_t exp_q[$];

  // Reference model state: 0 = hunting, 1 = in frame, 2 = frame captured.
  int         m_mode = 0;
  bit         m_seen = 1'b0;
  logic [7:0] m_bytes[$];
  int         m_pix = 0;
  int         m_idle = 0;

  logic [7:0] seq[12];

  always #5 clk = ~clk;

  uart_pixel_packer #(
    .W(W), .H(H), .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_index(pix_index),
    .frame_active(frame_active), .frame_done(frame_done), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (pix_valid) begin
      pix_t e;
      e.data = pix_data; e.index = pix_index; e.done = frame_done; e.active = frame_active;
      act_q.push_back(e);
    end
    if (frame_done && !pix_valid) stray_done++;
    if (frame_err) err_seen++;
  end

  // Pixels available after n frame bytes are floor(2n/3); pixel k lives in byte triple k/2.
  task automatic model_byte(input logic [7:0] b);
    int k, j;
    pix_t e;
    m_idle = 0;
    if (m_mode == 0) begin
      if (m_seen && b == 8'h55) begin
        m_mode = 1; m_bytes.delete(); m_pix = 0; m_seen = 1'b0;
      end else begin
        m_seen = (b == 8'hAA);
      end
    end else if (m_mode == 1) begin
      m_bytes.push_back(b);
      while (m_pix < (2 * m_bytes.size()) / 3) begin
        k = m_pix;
        j = 3 * (k / 2);
        if (k % 2 == 0) e.data = {m_bytes[j], m_bytes[j+1][7:4]};
        else            e.data = {m_bytes[j+1][3:0], m_bytes[j+2]};
        e.index  = 15'(k);
        e.done   = (k == TOTAL - 1);
        e.active = (k != TOTAL - 1);
        exp_q.push_back(e);
        m_pix++;
      end
      if (m_pix == TOTAL) m_mode = 2;
    end
  endtask

  task automatic model_idle(input int n);
    if (m_mode == 1) begin
      m_idle += n;
      if (m_idle >= TC_INT) begin
        m_mode = 0; m_seen = 1'b0; m_idle = 0; exp_err++;
      end
    end
  endtask

  task automatic model_drop();
    m_mode = 0; m_seen = 1'b0; m_idle = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    if (capture_en) model_idle(n);
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    if (capture_en) model_byte(b);
    idle(gap);
  endtask

  task automatic restart_capture();
    capture_en = 1'b0;
    model_drop();
    idle(2);
    capture_en = 1'b1;
  endtask

  task automatic send_frame(input int gap);
    drive_byte(8'hAA, gap);
    drive_byte(8'h55, gap);
    for (int i = 0; i < 12; i++) drive_byte(seq[i], gap);
  endtask

  task automatic applyStimulus_fixed_seq();
    seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
            8'hDE, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};
  endtask

  task automatic test_reset();
    rst = 1'b0; capture_en = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_valid: got %b want 0", pix_valid); end
    checks++; if (pix_data !== 12'h000) begin errors++; $display("[TB] FAIL reset_pix_data: got %h want 000", pix_data); end
    checks++; if (pix_index !== 15'd0) begin errors++; $display("[TB] FAIL reset_pix_index: got %0d want 0", pix_index); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b want 0", frame_active); end
    checks++; if ({frame_done, frame_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 00", {frame_done, frame_err}); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_pack();
    int e0;
    e0 = err_seen;
    applyStimulus_fixed_seq();
    restart_capture();
    drive_byte(8'hAA, 0);
    drive_byte(8'h55, 0);
    checks++; if (frame_active !== 1'b1) begin errors++; $display("[TB] FAIL pack_active_on_header: got %b want 1", frame_active); end
    drive_byte(seq[0], 0);
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL pack_no_strobe_b0: got %b want 0", pix_valid); end
    drive_byte(seq[1], 0);
    checks++; if ({pix_valid, pix_data, pix_index} !== {1'b1, 12'h123, 15'd0})
      begin errors++; $display("[TB] FAIL pack_latency: got v=%b d=%h i=%0d want v=1 d=123 i=0", pix_valid, pix_data, pix_index); end
    for (int i = 2; i < 12; i++) drive_byte(seq[i], 0);
    idle(2);
    checks++; if (frame_active !== 1'b0) begin errors++; $display("[TB] FAIL pack_active_after: got %b want 0", frame_active); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL pack_px%0d: got d=%h i=%0d done=%b act=%b want d=%h i=%0d done=%b act=%b", i,
                 act_q[i].data, act_q[i].index, act_q[i].done, act_q[i].active,
                 exp_q[i].data, exp_q[i].index, exp_q[i].done, exp_q[i].active);
      end
    end
    checks++; if (act_q.size() != exp_q.size() || exp_q.size() != 8) begin errors++; $display("[TB] FAIL pack_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    act_q.delete(); exp_q.delete();
    // Frame already captured: a new header must be ignored until capture_en drops.
    drive_byte(8'hAA, 0); drive_byte(8'h55, 0);
    for (int i = 0; i < 3; i++) drive_byte(seq[i], 0);
    idle(2);
    checks++; if (act_q.size() != 0) begin errors++; $display("[TB] FAIL done_ignores: got %0d strobes want 0", act_q.size()); end
    checks++; if (stray_done != 0 || err_seen != e0) begin errors++; $display("[TB] FAIL pack_pulses: got stray_done=%0d err=%0d want 0 0", stray_done, err_seen - e0); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_noise();
    restart_capture();
    drive_byte(8'h00, 1); drive_byte(8'hAA, 1); drive_byte(8'h00, 1);
    drive_byte(8'hAA, 1); drive_byte(8'hAA, 1);
    checks++; if (frame_active !== 1'b0) begin errors++; $display("[TB] FAIL noise_inactive: got %b want 0", frame_active); end
    drive_byte(8'h55, 1);
    checks++; if (frame_active !== 1'b1 || act_q.size() != 0) begin errors++; $display("[TB] FAIL noise_header: got act=%b strobes=%0d want 1 0", frame_active, act_q.size()); end
    for (int i = 0; i < 12; i++) drive_byte(seq[11 - i], 1);
    idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL noise_px%0d: got d=%h i=%0d done=%b want d=%h i=%0d done=%b", i,
                 act_q[i].data, act_q[i].index, act_q[i].done, exp_q[i].data, exp_q[i].index, exp_q[i].done);
      end
    end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL noise_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    int e0, x0;
    e0 = err_seen; x0 = exp_err;
    restart_capture();
    drive_byte(8'hAA, 0); drive_byte(8'h55, 0);
    for (int i = 0; i < 5; i++) drive_byte(seq[i], 0);
    idle(20);
    checks++; if (err_seen - e0 != 1) begin errors++; $display("[TB] FAIL timeout_err: got %0d pulses want 1", err_seen - e0); end
    checks++; if (act_q.size() != 3) begin errors++; $display("[TB] FAIL timeout_pix: got %0d pixels want 3", act_q.size()); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("[TB] FAIL timeout_active: got %b want 0", frame_active); end
    send_frame(0);
    idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL timeout_px%0d: got d=%h i=%0d want d=%h i=%0d", i,
                 act_q[i].data, act_q[i].index, exp_q[i].data, exp_q[i].index);
      end
    end
    checks++; if (act_q.size() != exp_q.size() || (err_seen - e0) != (exp_err - x0))
      begin errors++; $display("[TB] FAIL timeout_totals: got %0d px %0d err want %0d px %0d err", act_q.size(), err_seen - e0, exp_q.size(), exp_err - x0); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_exact_idle();
    int e0;
    e0 = err_seen;
    restart_capture();
    drive_byte(8'hAA, 0); drive_byte(8'h55, 0);
    for (int i = 0; i < 12; i++) drive_byte(seq[i], (i == 4) ? TC_INT - 1 : 0);
    idle(2);
    checks++; if (err_seen != e0) begin errors++; $display("[TB] FAIL exact_idle_err: got %0d pulses want 0", err_seen - e0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL exact_idle_px%0d: got d=%h i=%0d want d=%h i=%0d", i,
                 act_q[i].data, act_q[i].index, exp_q[i].data, exp_q[i].index);
      end
    end
    checks++; if (act_q.size() != exp_q.size() || exp_q.size() != 8) begin errors++; $display("[TB] FAIL exact_idle_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_capture_drop();
    int e0;
    e0 = err_seen;
    restart_capture();
    drive_byte(8'hAA, 0); drive_byte(8'h55, 0);
    for (int i = 0; i < 7; i++) drive_byte(seq[i], 0);
    capture_en = 1'b0;
    model_drop();
    idle(1);
    checks++; if (frame_active !== 1'b0) begin errors++; $display("[TB] FAIL drop_active: got %b want 0", frame_active); end
    drive_byte(8'h12, 0);
    idle(2);
    capture_en = 1'b1;
    send_frame(0);
    idle(2);
    checks++; if (err_seen != e0) begin errors++; $display("[TB] FAIL drop_err: got %0d pulses want 0", err_seen - e0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL drop_px%0d: got d=%h i=%0d want d=%h i=%0d", i,
                 act_q[i].data, act_q[i].index, exp_q[i].data, exp_q[i].index);
      end
    end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL drop_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    restart_capture();
    drive_byte(8'hAA, 0); drive_byte(8'h55, 0);
    drive_byte(8'h12, 0); drive_byte(8'h34, 0);
    checks++; if (pix_valid !== 1'b1 || frame_active !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: got v=%b act=%b want 1 1", pix_valid, frame_active); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({pix_valid, pix_data, pix_index, frame_active, frame_done, frame_err} !== 31'd0)
      begin errors++; $display("[TB] FAIL rst_async: got v=%b d=%h i=%0d act=%b want all 0", pix_valid, pix_data, pix_index, frame_active); end
    @(posedge clk); #1;
    rst = 1'b0;
    act_q.delete(); exp_q.delete();
    model_drop();
    drive_byte(8'h56, 0); drive_byte(8'h78, 0); drive_byte(8'h55, 0); drive_byte(8'h9A, 0);
    idle(2);
    checks++; if (act_q.size() != 0 || frame_active !== 1'b0) begin errors++; $display("[TB] FAIL rst_discard: got %0d strobes act=%b want 0 0", act_q.size(), frame_active); end
    send_frame(1);
    idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rst_px%0d: got d=%h i=%0d want d=%h i=%0d", i,
                 act_q[i].data, act_q[i].index, exp_q[i].data, exp_q[i].index);
      end
    end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rst_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int e0, x0, gap;
    e0 = err_seen; x0 = exp_err;
    for (int f = 0; f < 6; f++) begin
      restart_capture();
      for (int n = 0; n < 3; n++) drive_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      drive_byte(8'hAA, $urandom_range(0, 2));
      drive_byte(8'h55, $urandom_range(0, 2));
      for (int i = 0; i < 12; i++) begin
        gap = ($urandom_range(0, 11) == 0) ? TC_INT + 1 : $urandom_range(0, 3);
        drive_byte(8'($urandom_range(0, 255)), gap);
      end
      idle(TC_INT + 2);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_px%0d: got d=%h i=%0d done=%b want d=%h i=%0d done=%b", i,
                 act_q[i].data, act_q[i].index, act_q[i].done, exp_q[i].data, exp_q[i].index, exp_q[i].done);
      end
    end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    checks++; if ((err_seen - e0) != (exp_err - x0)) begin errors++; $display("[TB] FAIL rand_err: got %0d want %0d", err_seen - e0, exp_err - x0); end
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_pack();
    test_noise();
    test_timeout();
    test_exact_idle();
    test_capture_drop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_pixel_packer.md
Name: uart_pixel_packer

Overview:
- Sits directly upstream of the SPRAM frame-store controller.
- Converts the UART receiver's 8-bit byte stream into 12-bit RGB444 pixels, one `pix_valid` strobe per pixel.
- Detects a 2-byte frame header, counts exactly W*H pixels, and flags frame completion or a mid-frame timeout.
- Its `pix_valid`/`pix_data` drive the store's `rx_valid`/`rx_data`.

Parameters:
- W, 200, image width in pixels.
- H, 150, image height in pixels. W*H must be even and at most 32767.
- SYNC0, 8'hAA, first header byte.
- SYNC1, 8'h55, second header byte.
- TIMEOUT_CYCLES, 24'd5_000_000, idle clocks allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- capture_en  in  1  high while the top-level FSM is in the transfer state (8'h02); low forces HUNT0.
- byte_valid  in  1  one-cycle strobe from the UART receiver.
- byte_data  in  8  received byte; valid with `byte_valid`.
- pix_valid  out  1  one-cycle pixel strobe.
- pix_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}; held until the next strobe.
- pix_index  out  15  index of the pixel currently on `pix_data`, 0..W*H-1.
- frame_active  out  1  high from header accepted until frame end or abort.
- frame_done  out  1  one-cycle pulse together with the final pixel strobe.
- frame_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset, asynchronous: all outputs 0, state HUNT0, byte phase 0, pixel counter 0, timeout counter 0.
- Byte packing, two pixels per three bytes:
  - b0 = P0[11:4]
  - b1 = {P0[3:0], P1[11:8]}
  - b2 = P1[7:0]
- Byte phase counter cycles 0→1→2→0.
  - Phase 0 stores b0.
  - Phase 1 emits P0 = {b0, b1[7:4]} and stores b1[3:0].
  - Phase 2 emits P1 = {stored nibble, b2}.
- Latency: `pix_valid` is registered and asserted the cycle after the `byte_valid` that completes a pixel. No backpressure; the downstream must accept every strobe.
- `pix_index` updates together with `pix_data`. It is 0 for the first pixel of each frame.
- States:
  - HUNT0: on a byte equal to SYNC0 → HUNT1; any other byte is discarded.
  - HUNT1: on SYNC1 → DATA, with phase, counter and timeout cleared and `frame_active` set. On SYNC0 stay in HUNT1. Any other byte → HUNT0.
  - DATA: pack bytes as above. When the emitted pixel is number W*H-1, pulse `frame_done` with that `pix_valid`, clear `frame_active` and go to DONE.
  - DONE: ignore all bytes until `capture_en` falls, then → HUNT0. Exactly one frame is captured per transfer-state entry.
- Header bytes inside DATA are pixel data, not resync.
- Timeout, DATA state only:
  - The counter increments every clock without `byte_valid` and clears on any `byte_valid`.
  - When it reaches TIMEOUT_CYCLES-1: pulse `frame_err`, clear `frame_active`, phase and counter, and go to HUNT0.
  - If `byte_valid` arrives in the same cycle as the terminal count, the byte wins and there is no error.
- `capture_en` low in any state: → HUNT0 next clock, clear phase/counter/`frame_active`, no `frame_err`. A partial pixel in flight is dropped.
- `byte_valid` while `capture_en` is low: ignored.
- Widths:
  - Pixel counter is 15 bits; frame end is compared against the constant W*H-1.
  - Timeout counter is 24 bits and saturates at the terminal count.

Decomposition:
- Shared package `frame_pkg`:
  - localparam PIX_TOTAL = W*H
  - pixel width 12
  - SYNC0/SYNC1 defaults
  - state enum {HUNT0, HUNT1, DATA, DONE}
- Later frame-path blocks reuse the same package.
- One natural sub-module, `byte_timeout`: a 24-bit idle counter with clear and terminal-count output, reusable by the UART receiver.
- The packing datapath stays inline.

Test Plan (W=4, H=2, TIMEOUT_CYCLES=16 unless noted):
- Header then 12 bytes 12 34 56 ... → 8 `pix_valid` strobes. Pixel 0 = 12'h123, pixel 1 = 12'h456, etc. `frame_done` coincides with `pix_index` 7; `frame_active` falls the same cycle.
- Noise 00 AA 00 AA AA 55 then data → HUNT0/HUNT1 transitions are correct. The first pixel follows only the final AA 55; no strobes during the noise.
- In DATA, after 5 bytes, stop for 16 cycles → `frame_err` pulses once, exactly 3 pixels were emitted, next AA 55 restarts with `pix_index` 0.
- A byte arrives exactly at idle count 15 → no `frame_err`, frame completes normally.
- `capture_en` dropped mid-frame after 4 pixels, then re-raised with a full frame → no `frame_err`; the new frame emits 8 pixels starting at index 0.
- `rst` asserted mid-frame → all outputs read 0 asynchronously. Bytes after the release of `rst` are discarded until AA 55.
